// File: rtl/gpio_map_pkg.sv
// GPIO register map shared by the stream reader and writer: bit positions of
// the strobe and address fields, fixed register addresses, and FSM states.
package gpio_map_pkg;

  localparam int STROBE_BIT = 31;
  localparam int ADDR_LSB   = 16;

  localparam logic [7:0] CH_BASE     = 8'h20;
  localparam logic [7:0] STATUS_ADDR = 8'h1F;
  localparam logic [7:0] RESYNC_ADDR = 8'h1E;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/gpio_strobe_sync.sv
// Two-flop synchroniser for the CPU strobe plus a history flop, giving a
// one-cycle rise indication and a level fall indication. Shared with the
// GPIO writer.
module gpio_strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // Synchronise the asynchronous strobe and keep one cycle of history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the old value of
      // its predecessor, which is what makes this a real shift chain.
      s1 <= strobe;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2;

endmodule

// File: rtl/gpio_stream_reader.sv
// CPU readback port: serialises DATA_W-bit AXI-Stream words from NUM_CH
// channels into 16-bit slices over the 32-bit GPIO interface, with a live
// status register and a slice-counter resync command.
// Optional feature: define GPIO_STREAM_READER_STATS_EN to add per-channel
// 16-bit saturating underflow counters at CH_BASE+NUM_CH+k.
module gpio_stream_reader #(
  parameter int                NUM_CH      = 4,
  parameter int                DATA_W      = 128,
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] CH_BASE     = gpio_map_pkg::CH_BASE,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = gpio_map_pkg::STATUS_ADDR,
  parameter logic [ADDR_W-1:0] RESYNC_ADDR = gpio_map_pkg::RESYNC_ADDR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              gpio_in,
  output logic [15:0]              gpio_out,
  output logic                     ack,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_valid,
  output logic [NUM_CH-1:0]        ch_ready
);
  import gpio_map_pkg::*;

  localparam int SLICES = DATA_W / 16;
  localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0]  LAST_SLICE = CNT_W'(SLICES - 1);
  localparam logic [ADDR_W-1:0] NUM_CH_A   = ADDR_W'(NUM_CH);

  // Address decode (address is sampled unsynchronised; the CPU keeps it stable)
  logic [ADDR_W-1:0] addr, ch_off;
  logic              is_ch, is_status, is_resync;
  logic [CH_W-1:0]   ch_idx;
  logic              rise, fall;
  logic              unused_bits;

  assign addr      = gpio_in[ADDR_LSB +: ADDR_W];
  assign ch_off    = addr - CH_BASE;
  assign is_ch     = (addr >= CH_BASE) && (ch_off < NUM_CH_A);
  assign ch_idx    = ch_off[CH_W-1:0];
  assign is_status = (addr == STATUS_ADDR);
  assign is_resync = (addr == RESYNC_ADDR);
  assign unused_bits = ^{gpio_in[STROBE_BIT-1:ADDR_LSB+ADDR_W], gpio_in[ADDR_LSB-1:0]};

  gpio_strobe_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .strobe (gpio_in[STROBE_BIT]),
    .rise   (rise),
    .fall   (fall)
  );

  // Per-channel view of the flattened stream data
  logic [DATA_W-1:0] words [NUM_CH];
  for (genvar g = 0; g < NUM_CH; g++) begin : g_words
    assign words[g] = ch_data[g*DATA_W +: DATA_W];
  end

  fsm_state_t        state_q, state_d;
  logic              ack_d;
  logic [NUM_CH-1:0] ready_d;
  logic [15:0]       out_q, out_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  cur_cnt;
  logic [15:0]       cur_slice;

  assign cur_cnt   = cnt_q[ch_idx];
  assign cur_slice = words[ch_idx][{cur_cnt, 4'b0000} +: 16];

`ifdef GPIO_STREAM_READER_STATS_EN
  logic [15:0]       uf_q [NUM_CH];
  logic [15:0]       uf_d [NUM_CH];
  logic [ADDR_W-1:0] uf_off;
  logic              is_uf;
  assign uf_off = addr - (CH_BASE + NUM_CH_A);
  assign is_uf  = (addr >= CH_BASE + NUM_CH_A) && (uf_off < NUM_CH_A);
`endif

  // Next-state and next-register values for one strobed read
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d = state_q;
    ack_d   = ack;
    ready_d = '0;
    out_d   = out_q;
    cnt_d   = cnt_q;
`ifdef GPIO_STREAM_READER_STATS_EN
    uf_d    = uf_q;
`endif
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HOLD;
          if (is_ch) begin
            if (ch_valid[ch_idx]) begin
              out_d = cur_slice;
              ack_d = 1'b1;
              if (cur_cnt == LAST_SLICE) begin
                ready_d[ch_idx] = 1'b1;
                cnt_d[ch_idx]   = '0;
              end else begin
                cnt_d[ch_idx] = cur_cnt + 1'b1;
              end
            end
`ifdef GPIO_STREAM_READER_STATS_EN
            else if (uf_q[ch_idx] != 16'hFFFF) begin
              uf_d[ch_idx] = uf_q[ch_idx] + 16'd1;
            end
`endif
          end else if (is_resync) begin
            for (int i = 0; i < NUM_CH; i++) begin
              cnt_d[i] = '0;
`ifdef GPIO_STREAM_READER_STATS_EN
              uf_d[i]  = '0;
`endif
            end
            ack_d = 1'b1;
          end else begin
            ack_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (fall) begin
          state_d = IDLE;
          ack_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, handshake and slice-counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ack      <= 1'b0;
      ch_ready <= '0;
      out_q    <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, and a reset
      // mid-word must restart reading at slice 0, so every entry is cleared.
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
`ifdef GPIO_STREAM_READER_STATS_EN
        uf_q[i]  <= '0;
`endif
      end
    end else begin
      state_q  <= state_d;
      ack      <= ack_d;
      ch_ready <= ready_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
`ifdef GPIO_STREAM_READER_STATS_EN
      uf_q     <= uf_d;
`endif
    end
  end

  // Readback mux, combinational from the current address
  always_comb begin
    gpio_out = 16'h0000;
    if (is_ch) begin
      gpio_out = out_q;
    end else if (is_status) begin
      gpio_out = 16'(ch_valid);
    end
`ifdef GPIO_STREAM_READER_STATS_EN
    else if (is_uf) begin
      gpio_out = uf_q[uf_off[CH_W-1:0]];
    end
`endif
  end

endmodule

// File: tb/tb_gpio_stream_reader.sv
// Directed bench for gpio_stream_reader (NUM_CH=4, DATA_W=128). A read-level
// model tracks slice positions, underflow counts and expected ready pulses;
// a per-cycle monitor compares live outputs against that model.
module tb_gpio_stream_reader;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 128;
  localparam int SLICES = DATA_W / 16;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [31:0]              gpio_in = '0;
  logic [15:0]              gpio_out;
  logic                     ack;
  logic [NUM_CH*DATA_W-1:0] ch_data = '0;
  logic [NUM_CH-1:0]        ch_valid = '1;
  logic [NUM_CH-1:0]        ch_ready;

  gpio_stream_reader #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .ack      (ack),
    .ch_data  (ch_data),
    .ch_valid (ch_valid),
    .ch_ready (ch_ready)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Model state
  logic [15:0] base_v [NUM_CH] = '{16'hA000, 16'h0000, 16'hB200, 16'hC300};
  int          model_cnt [NUM_CH] = '{0, 0, 0, 0};
  int          model_uf  [NUM_CH] = '{0, 0, 0, 0};
  int          exp_ready [NUM_CH] = '{0, 0, 0, 0};
  int          ready_cnt [NUM_CH] = '{0, 0, 0, 0};
  logic [15:0] model_out = '0;
  logic [NUM_CH-1:0] prev_ready = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Value gpio_out must show while ack is high, from the model's view
  function automatic logic [15:0] exp_live(input logic [7:0] a);
    if (a >= 8'h20 && a < 8'h24) return model_out;
    if (a == 8'h1F) return 16'(ch_valid);
`ifdef GPIO_STREAM_READER_STATS_EN
    if (a >= 8'h24 && a < 8'h28) return 16'(model_uf[a - 8'h24]);
`endif
    return 16'h0000;
  endfunction

  // Per-cycle monitor: ready is one-hot and single-cycle, live readback matches
  always @(negedge clk) begin
    if (rst) begin
      check("ready_onehot0", 32'($onehot0(ch_ready)), 32'd1);
      check("ready_one_cycle", 32'(ch_ready & prev_ready), 32'd0);
      if (ack) check("live_gpio_out", 32'(gpio_out), 32'(exp_live(gpio_in[23:16])));
      for (int k = 0; k < NUM_CH; k++) if (ch_ready[k]) ready_cnt[k]++;
    end
    prev_ready = ch_ready;
  end

  // One strobed read with model prediction, latency and ready bookkeeping
  task automatic do_read(input logic [7:0] addr, input bit hold, output logic [15:0] data);
    bit          is_ch, exp_ack, got;
    int          k, lat;
    logic [15:0] exp_d;
    is_ch   = (addr >= 8'h20) && (addr < 8'h24);
    k       = is_ch ? int'(addr - 8'h20) : 0;
    exp_ack = !is_ch || ch_valid[k];
    exp_d   = is_ch ? 16'(base_v[k] + 16'(model_cnt[k])) : exp_live(addr);

    @(negedge clk);
    gpio_in = {8'h00, addr, 16'h0000};
    repeat (2) @(negedge clk);
    if (is_ch && exp_ack) model_out = exp_d;
    gpio_in[31] = 1'b1;

    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ack) begin got = 1'b1; break; end
    end
    check("ack_seen", 32'(got), 32'(exp_ack));
    data = gpio_out;
    if (exp_ack && got) begin
      check("ack_latency", lat, 3);
      check("read_data", 32'(gpio_out), 32'(exp_d));
    end

    if (is_ch && ch_valid[k]) begin
      model_cnt[k] = (model_cnt[k] + 1) % SLICES;
      if (model_cnt[k] == 0) exp_ready[k]++;
    end else if (is_ch) begin
      if (model_uf[k] < 65535) model_uf[k]++;
    end else if (addr == 8'h1E) begin
      for (int j = 0; j < NUM_CH; j++) begin
        model_cnt[j] = 0;
        model_uf[j]  = 0;
      end
    end

    if (!hold) begin
      @(negedge clk);
      gpio_in[31] = 1'b0;
      got = 1'b0;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        lat++;
        if (!ack) begin got = 1'b1; break; end
      end
      check("ack_release", 32'(got), 32'd1);
      if (exp_ack) check("ack_drop_latency", lat, 3);
      for (int j = 0; j < NUM_CH; j++) check("ready_pulses", ready_cnt[j], exp_ready[j]);
    end
  endtask

  logic [15:0] d;

  initial begin
    for (int k = 0; k < NUM_CH; k++)
      for (int s = 0; s < SLICES; s++)
        ch_data[k*DATA_W + s*16 +: 16] = base_v[k] + 16'(s);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_ready", 32'(ch_ready), 32'd0);
    check("rst_gpio_out", 32'(gpio_out), 32'd0);
    @(negedge clk);
    gpio_in = 32'h001F_0000;
    #1 check("rst_status_mux", 32'(gpio_out), 32'h000F);
    @(negedge clk);
    gpio_in = '0;
    rst = 1'b1;

    // Slice order on channel 1: 0000..0007, one ready pulse after the 8th read
    for (int i = 0; i < SLICES; i++) begin
      do_read(8'h21, 1'b0, d);
      check("slice_order", 32'(d), 32'(i));
      check("ch1_ready_count", ready_cnt[1], (i == SLICES - 1) ? 1 : 0);
    end

    // Empty read on channel 0, then retry with valid
    ch_valid[0] = 1'b0;
    do_read(8'h20, 1'b0, d);
    ch_valid[0] = 1'b1;
    do_read(8'h20, 1'b0, d);
    check("empty_retry_slice0", 32'(d), 32'h0000_A000);

    // Resync: three reads, resync, next read restarts at slice 0
    for (int i = 0; i < 3; i++) do_read(8'h22, 1'b0, d);
    check("ch2_third_slice", 32'(d), 32'h0000_B202);
    do_read(8'h1E, 1'b0, d);
    do_read(8'h22, 1'b0, d);
    check("resync_slice0", 32'(d), 32'h0000_B200);
    check("resync_no_ready", ready_cnt[2], 0);

    // Status register
    ch_valid = 4'b1010;
    do_read(8'h1F, 1'b0, d);
    check("status_value", 32'(d), 32'h0000_000A);
    ch_valid = 4'b1111;

    // Unmapped address reads zero with ack
    do_read(8'h05, 1'b0, d);
    check("other_addr_zero", 32'(d), 32'h0);

`ifdef GPIO_STREAM_READER_STATS_EN
    ch_valid[3] = 1'b0;
    for (int i = 0; i < 3; i++) do_read(8'h23, 1'b0, d);
    ch_valid[3] = 1'b1;
    do_read(8'h27, 1'b0, d);
    check("uf_count3", 32'(d), 32'h0003);
    do_read(8'h1E, 1'b0, d);
    do_read(8'h27, 1'b0, d);
    check("uf_cleared", 32'(d), 32'h0000);
`else
    do_read(8'h27, 1'b0, d);
    check("uf_addr_zero", 32'(d), 32'h0000);
`endif

    // Reset mid-read: hold in HOLD after slice 5, then reset
    for (int i = 0; i < 5; i++) do_read(8'h23, 1'b0, d);
    do_read(8'h23, 1'b1, d);
    check("ch3_slice5", 32'(d), 32'h0000_C305);
    #2 rst = 1'b0;
    #1;
    check("midread_rst_ack", 32'(ack), 32'd0);
    check("midread_rst_ready", 32'(ch_ready), 32'd0);
    gpio_in = '0;
    model_out = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      model_cnt[j] = 0;
      model_uf[j]  = 0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_read(8'h23, 1'b0, d);
    check("after_rst_slice0", 32'(d), 32'h0000_C300);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/gpio_stream_reader.md
Name: gpio_stream_reader

Overview:
- Parametrised CPU readback port that serialises wide AXI-Stream words from NUM_CH channels into 16-bit slices over the 32-bit GPIO interface.
- The CPU sets an address, raises a strobe, and waits for ack. Each read returns one slice. The stream beat is consumed after its last slice.
- Also provides a live status register and a slice-counter resync command.
- Sits between the ADC/result FIFOs (MAC, NL, A, C) and the PS GPIO block.

Parameters:
- NUM_CH, 4, number of stream channels (1..16).
- DATA_W, 128, stream word width; multiple of 16, 16..256.
- ADDR_W, 8, GPIO address field width.
- CH_BASE, 8'h20, address of channel 0; channel k is at CH_BASE+k.
- STATUS_ADDR, 8'h1F, status register address.
- RESYNC_ADDR, 8'h1E, address that clears all slice counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- gpio_in  in  32  bit31 strobe; bits[ADDR_W+15:16] address; other bits ignored.
- gpio_out  out  16  readback data (combinational from address).
- ack  out  1  read complete; held high until strobe falls.
- ch_data  in  NUM_CH*DATA_W  channel k occupies [k*DATA_W +: DATA_W].
- ch_valid  in  NUM_CH  AXIS valid per channel.
- ch_ready  out  NUM_CH  AXIS ready per channel; single-cycle pulse.

Behaviour:
- Constants: SLICES = DATA_W/16; CNT_W = max(1, clog2(SLICES)).
- Strobe sync: bit31 passes through two flops (s1, s2) plus a history flop s3. rise = s2&!s3; fall = !s2.
- The address is sampled unsynchronised. CPU contract: address is stable at least 2 clk before strobe rises, and until ack is seen.
- FSM states: IDLE and HOLD.
- IDLE, on rise: always go to HOLD.
  - Channel address with ch_valid[k]=1: out_reg <= ch_data slice [cnt[k]*16 +: 16]; ack <= 1.
    - If cnt[k]==SLICES-1: ch_ready[k] <= 1 for one cycle; cnt[k] <= 0.
    - Otherwise: cnt[k] <= cnt[k]+1.
  - Channel address with ch_valid[k]=0 (empty): ack stays 0; out_reg and cnt unchanged. CPU must time out and retry.
  - RESYNC_ADDR: all cnt <= 0; ack <= 1.
  - Any other address: ack <= 1 (plain register read).
- HOLD: ch_ready <= 0 at the next edge. On fall: go to IDLE, ack <= 0.
- Latency: registers update at the 3rd clk edge after strobe is first sampled high. ack drops at the 3rd edge after strobe is first sampled low.
- Only one ch_ready bit is ever high, for exactly one cycle per DATA_W word.
- gpio_out mux:
  - channel address: out_reg.
  - STATUS_ADDR: ch_valid zero-extended to 16 bits.
  - anything else: 16'h0000.
- Reset values: ack=0, ch_ready=0, out_reg=0, all cnt=0, state=IDLE, sync flops=0. gpio_out follows the address (0 or ch_valid).
- Strobe held high indefinitely: stays in HOLD; no further reads.
- Strobe pulse shorter than 2 clk: may be missed; this is legal and the CPU times out.
- Reset mid-read: ack drops immediately; slice counters restart at 0. A partially read word is re-read from slice 0.
- An upstream valid drop mid-word violates AXIS and is not handled.

Optional Feature:
- Macro: GPIO_STREAM_READER_STATS_EN.
- With the macro defined:
  - Each channel has a 16-bit saturating underflow counter, incremented on every empty read.
  - Readable at CH_BASE+NUM_CH+k.
  - A RESYNC read also clears all underflow counters.
- Without the macro: those addresses read 0 and the counters are not instantiated.

Decomposition:
- Package gpio_map_pkg holds:
  - GPIO bit positions (STROBE_BIT=31, ADDR_LSB=16).
  - Address constants: CH_BASE, STATUS_ADDR, RESYNC_ADDR.
  - The fsm_state_t enum {IDLE, HOLD}.
- Sub-module gpio_strobe_sync provides the 2-flop synchroniser with rise/fall outputs. It is reusable by the GPIO writer.

Test Plan:
- Slice order: NUM_CH=4, DATA_W=128. Channel 1 word = 128'h0007_0006_0005_0004_0003_0002_0001_0000. Do 8 strobed reads at 8'h21 -> gpio_out returns 0000 through 0007 in order; ch_ready[1] pulses once, after the 8th read only.
- Empty read: ch_valid=0, read 8'h20 -> ack stays 0 for 20 cycles; cnt[0] unchanged. Then assert valid and retry -> slice 0 returned.
- Resync: 3 reads on channel 2, then a read at 8'h1E, then a channel 2 read -> slice 0 returned; no ch_ready pulse.
- Status: ch_valid=4'b1010, read 8'h1F -> gpio_out = 16'h000A, ack=1.
- Reset mid-read: assert rst while in HOLD after slice 5 -> ack=0 and ch_ready=0 immediately. After release, a read returns slice 0.
- Stats (macro on): 3 empty reads on channel 3; read 8'h27 -> 16'h0003. Then a read at 8'h1E, then 8'h27 -> 16'h0000.
